// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle adder/subtractor that pushes one 4-bit
// nibble per clock through a single ripple slice, least-significant nibble
// first, keeping the inter-nibble carry in a register. Valid/ready
// handshakes on both the operand and the result side.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_slice;
    logic [3:0]       w_sum;
    logic             w_cy;

    // The single 4-bit ripple slice shared by every nibble step.
    function automatic logic [4:0] slice_add(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_nib  = r_a[4*r_idx +: 4];
    assign w_b_nib  = r_b[4*r_idx +: 4];
    assign w_slice  = slice_add(w_a_nib, w_b_nib, r_carry);
    assign w_sum    = w_slice[3:0];
    assign w_cy     = w_slice[4];

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture; subtraction is a + ~b + 1, the +1 entering as carry.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= sub ? ~b : b;
        end
    end

    // Nibble index, carry chain and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_carry <= sub ? 1'b1 : cin;
        end else if (r_state == S_RUN) begin
            r_s[4*r_idx +: 4] <= w_sum;
            r_carry           <= w_cy;
            if (w_last) begin
                r_cout <= w_cy;
                // Carry into the MSB is a^b^sum at that bit; xor with carry out.
                r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[3] ^ w_cy;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: directed corner cases plus randomized
// operations compared against a plain-integer arithmetic reference.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the unsigned and signed readings.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int ua, ub, sa, sb, r, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            r  = ua + ub + int'(mcin);
            sr = sa + sb + int'(mcin);
            ec = (r > 65535);
        end else begin
            r  = ua - ub;
            sr = sa - sb;
            ec = (ua >= ub);
        end
        es = r[W-1:0];
        eo = (sr > 32767) || (sr < -32768);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    // One full operation; 'hold' cycles of backpressure in DONE with noisy inputs.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input int hold);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat;
        model(ta, tb, tcin, tsub, es, ec, eo);
        wait_ready();
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = ~tsub;
        chk("in_ready_run", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NIB));
        chk("s", 64'(s), 64'(es));
        chk("cout", 64'(cout), 64'(ec));
        chk("ovf", 64'(ovf), 64'(eo));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_s", 64'(s), 64'(es));
            chk("hold_cout_ovf", 64'({cout, ovf}), 64'({ec, eo}));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("post_hs_ready", 64'(in_ready), 64'd1);
        chk("post_hs_s", 64'(s), 64'(es));
    endtask

    initial begin
        logic [W-1:0] qa [4];
        logic [W-1:0] qb [4];
        logic [W-1:0] es;
        logic         ec, eo;
        int           last_cyc;
        int           g;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_flags", 64'({out_valid, cout, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0);

        // Asynchronous reset two cycles into RUN
        wait_ready();
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("partial_s", 64'(s), 64'h0022);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_s", 64'(s), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_flags", 64'({cout, ovf}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        // Randomized operations with random backpressure
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        // Back-to-back: accept -> 4 RUN cycles -> 1 DONE cycle -> 1 IDLE cycle,
        // so with out_ready tied high a new result appears every NIB+2 cycles.
        for (int i = 0; i < 4; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
        end
        out_ready = 1'b1;
        cin = 1'b0; sub = 1'b0;
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            a = qa[i]; b = qb[i]; in_valid = 1'b1;
            wait_ready();
            @(posedge clk); #1;
            if (i < 3) begin
                a = qa[i+1]; b = qb[i+1];
            end
            g = 0;
            while (!out_valid && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            model(qa[i], qb[i], 1'b0, 1'b0, es, ec, eo);
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_s", 64'(s), 64'(es));
            chk("b2b_cout_ovf", 64'({cout, ovf}), 64'({ec, eo}));
            if (i > 0) chk("b2b_interval", 64'(cyc - last_cyc), 64'(NIB + 2));
            last_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
